// File: rtl/b14_mem_pkg.sv
// b14_mem_pkg: shared constants for the b14 memory responder.
//   Default bus/RAM widths, error flag bit positions, traffic counter width and
//   its saturation value, plus a saturating-increment helper.
package b14_mem_pkg;

   localparam int unsigned DEF_ADDR_W     = 20;
   localparam int unsigned DEF_DATA_W     = 31;
   localparam int unsigned DEF_DEPTH_LOG2 = 5;

   localparam int unsigned ERR_OOB  = 0;
   localparam int unsigned ERR_COLL = 1;

   localparam int unsigned      CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/b14_mem_rdpipe.sv
// b14_mem_rdpipe: RD_LAT-deep shift register of {valid, data} for read returns.
//   Ports:
//     clock     in   rising-edge clock
//     reset     in   synchronous active-high reset, clears valids and data
//     in_valid  in   a read is launched this cycle
//     in_data   in   data launched with the read
//     datai     out  last completed read data, held between reads
//     rd_valid  out  one-cycle pulse when datai was updated
module b14_mem_rdpipe #(
   parameter int unsigned DATA_W = 31,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] datai,
   output logic              rd_valid
);

   logic [RD_LAT-1:0] valid_q;
   logic [DATA_W-1:0] data_q [RD_LAT];

   // Each data stage only loads when a valid entry arrives, so the last stage
   // naturally holds the previous result between reads.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
         for (int k = 0; k < int'(RD_LAT); k++) begin
            data_q[k] <= '0;
         end
      end else begin
         valid_q[0] <= in_valid;
         if (in_valid) begin
            data_q[0] <= in_data;
         end
         for (int k = 1; k < int'(RD_LAT); k++) begin
            valid_q[k] <= valid_q[k-1];
            if (valid_q[k-1]) begin
               data_q[k] <= data_q[k-1];
            end
         end
      end
   end

   assign datai    = data_q[RD_LAT-1];
   assign rd_valid = valid_q[RD_LAT-1];

endmodule

// File: rtl/b14_mem_port.sv
// b14_mem_port: word RAM responder for the b14 core bus.
//   Ports:
//     clock, reset               rising-edge clock, synchronous active-high reset
//     addr, datao, rd, wr        core request (word address, write data, strobes)
//     datai, rd_valid            read return after RD_LAT edges (RD_LAT in 1..4)
//     load_en/addr/data          side-band preload, honoured even in reset
//     rd_count, wr_count         saturating counts of accepted in-range accesses
//     err, err_clr               sticky {collision, out-of-range} flags and clear
module b14_mem_port
   import b14_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
   parameter int unsigned RD_LAT     = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     datao,
   input  logic                  rd,
   input  logic                  wr,
   output logic [DATA_W-1:0]     datai,
   output logic                  rd_valid,
   input  logic                  load_en,
   input  logic [DEPTH_LOG2-1:0] load_addr,
   input  logic [DATA_W-1:0]     load_data,
   output logic [CNT_W-1:0]      rd_count,
   output logic [CNT_W-1:0]      wr_count,
   output logic [1:0]            err,
   input  logic                  err_clr
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0]     mem_q [DEPTH];
   logic [CNT_W-1:0]      rd_count_q, rd_count_d;
   logic [CNT_W-1:0]      wr_count_q, wr_count_d;
   logic [1:0]            err_q, err_d, err_set;
   logic                  in_range;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  core_rd, core_wr, wr_ok, rd_ok;
   logic [DATA_W-1:0]     rd_data;

   assign in_range = (addr[ADDR_W-1:DEPTH_LOG2] == '0);
   assign idx      = addr[DEPTH_LOG2-1:0];
   assign core_rd  = rd & ~reset;
   assign core_wr  = wr & ~reset;
   // A preload in the same cycle steals the RAM write port from the core.
   assign wr_ok    = core_wr & ~load_en & in_range;
   assign rd_ok    = core_rd & in_range;
   // Combinational read of the pre-edge contents gives read-before-write.
   assign rd_data  = in_range ? mem_q[idx] : '0;

   always_ff @(posedge clock) begin
      if (load_en) begin
         mem_q[load_addr] <= load_data;
      end else if (wr_ok) begin
         mem_q[idx] <= datao;
      end
   end

   always_comb begin
      err_set           = '0;
      err_set[ERR_OOB]  = (core_rd & ~in_range) | (core_wr & ~load_en & ~in_range);
      err_set[ERR_COLL] = core_wr & load_en;
      rd_count_d        = rd_ok ? sat_inc(rd_count_q) : rd_count_q;
      wr_count_d        = wr_ok ? sat_inc(wr_count_q) : wr_count_q;
      // A new error in the clearing cycle survives the clear.
      err_d             = err_clr ? err_set : (err_q | err_set);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_count_q <= '0;
         wr_count_q <= '0;
         err_q      <= '0;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
         err_q      <= err_d;
      end
   end

   b14_mem_rdpipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rdpipe (
      .clock    (clock),
      .reset    (reset),
      .in_valid (core_rd),
      .in_data  (rd_data),
      .datai    (datai),
      .rd_valid (rd_valid)
   );

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
   assign err      = err_q;

endmodule

// File: doc/b14_mem_port.md
# b14_mem_port

Synthesizable memory responder that sits directly downstream of the `b14` core's bus. It services the core's `rd`/`wr` requests on `addr`/`datao` from a small on-chip word RAM and drives the core's `datai` input with a fixed, parameterized read latency. A side-band preload port fills the RAM while the core is held in reset. Saturating traffic counters and sticky error flags are provided for bench observation.

## Interface
Parameters:
- `ADDR_W`, 20, core address width
- `DATA_W`, 31, data word width
- `DEPTH_LOG2`, 5, RAM depth = 2^DEPTH_LOG2 words
- `RD_LAT`, 1, read latency in clock edges; legal range 1..4

Ports:
- `clock`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `addr`  in  ADDR_W  core word address
- `datao`  in  DATA_W  core write data
- `rd`  in  1  core read strobe
- `wr`  in  1  core write strobe
- `datai`  out  DATA_W  read data to core; holds last value between reads
- `rd_valid`  out  1  one-cycle pulse; `datai` was updated at this edge
- `load_en`  in  1  preload write strobe
- `load_addr`  in  DEPTH_LOG2  preload address
- `load_data`  in  DATA_W  preload data
- `rd_count`  out  16  accepted in-range reads, saturating
- `wr_count`  out  16  accepted in-range writes, saturating
- `err`  out  2  sticky flags: bit0 = out-of-range access, bit1 = load/core-write collision
- `err_clr`  in  1  clears `err` at the next edge

## Operation
- **In range:** an access is in range when `addr[ADDR_W-1:DEPTH_LOG2] == 0`. The index is `addr[DEPTH_LOG2-1:0]`.
- **Write:** `wr` in range stores `datao` to the RAM at the index and increments `wr_count`.
- **Write, out of range:** the write is dropped and `err[0]` is set.
- **Read:** `rd` in range reads `mem[index]` and launches it into the latency pipeline. `rd_count` increments.
- **Read, out of range:** the read launches 0 into the pipeline, sets `err[0]`, and does not increment `rd_count`.
- **`rd` and `wr` together:** the write is performed and the read returns the OLD content (read-before-write). Both counters increment.
- **Preload:** `load_en` writes `load_data` to `mem[load_addr]`. It has priority over a core write in the same cycle. In that case the core write is dropped and `err[1]` is set, regardless of address. A core read in that cycle proceeds and sees the pre-load content.
- **`datai` between reads:** retains its value when no read completes.
- **Counters:** saturate at 16'hFFFF. They never wrap.
- **`err` update:** set has priority over `err_clr` when both occur in the same cycle.
- **Reset:**
  - Clears `datai`=0, `rd_valid`=0, the pipeline valid bits, both counters and `err`.
  - RAM contents are NOT cleared, so preloaded data survives reset.
  - `load_en` is honoured during reset. Core `rd`/`wr` are ignored during reset.
  - Reset mid-read discards all in-flight reads: no `rd_valid` pulse follows.

## Timing
- **Read latency:** a read sampled at edge E updates `datai` and pulses `rd_valid` at edge E+RD_LAT-1.
  - RD_LAT=1: `datai` is registered directly at the sampling edge.
  - Back-to-back reads every cycle are fully pipelined, one result per cycle in order.
- **Write visibility:** a write at edge E is visible to a read sampled at edge E+1 or later.
- **Counters and `err`:** update at the same edge that samples the access.
- **Combinational paths:** none from inputs to outputs.

## Structure
- **Package `b14_mem_pkg`:**
  - Default widths (`ADDR_W`, `DATA_W`, `DEPTH_LOG2`).
  - Error bit indices `ERR_OOB`=0 and `ERR_COLL`=1.
  - Counter width 16 and the saturation constant.
- **Sub-module `b14_mem_rdpipe`:** parameterized RD_LAT-deep shift register of {valid, data}, synchronous reset clearing the valid bits. It produces `datai` and `rd_valid`.
- **Top level:** RAM array, access decode, counters and error logic.

## Test plan
- **Preload then read:** load mem[3]=31'h0ABCDEF during reset, release reset, `rd` with addr=3, RD_LAT=1 -> `datai`=31'h0ABCDEF and `rd_valid`=1 at the sampling edge; `rd_count`=1.
- **Simultaneous rd/wr:** mem[5]=7; cycle with `rd`=`wr`=1, addr=5, `datao`=9 -> `datai`=7. A read the next cycle -> `datai`=9; `wr_count`=1 and `rd_count`=2.
- **Out of range:** `rd` with addr=20'h00020 (DEPTH_LOG2=5) -> `datai`=0, `err[0]`=1, `rd_count` unchanged. `err_clr` -> `err`=0 next edge.
- **Collision:** `load_en` with load_addr=2 and core `wr` with addr=7 in the same cycle -> mem[2] loaded, mem[7] unchanged, `err[1]`=1.
- **Pipelined latency:** RD_LAT=3, reads of addr 0,1,2 on consecutive cycles -> three consecutive `rd_valid` pulses starting two edges after the first read, data in order. Assert `reset` after the first pulse -> no further pulses, `datai`=0.
- **Saturation:** force 65,536 in-range writes -> `wr_count` holds at 16'hFFFF.
